// File: rtl/hwpe_ctrl_ucode_seq_if.sv
// hwpe_ctrl_ucode_seq_if: microcode image and read-only operands in, loop indices and offsets out.
interface hwpe_ctrl_ucode_seq_if #(
   parameter int NB_LOOPS  = 6,
   parameter int LENGTH    = 17,
   parameter int NB_REG    = 4,
   parameter int NB_RO_REG = 28,
   parameter int REG_WIDTH = 32,
   parameter int CNT_WIDTH = 12
);
   logic                                clear_i;
   logic                                enable_i;
   logic [$clog2(NB_LOOPS)-1:0]         accum_loop_i;
   logic [NB_LOOPS-1:0][7:0]            loops_i;
   logic [LENGTH-1:0][10:0]             code_i;
   logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  range_i;
   logic [NB_RO_REG-1:0][REG_WIDTH-1:0] ro_reg_i;
   logic                                valid_o;
   logic                                done_o;
   logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  idx_o;
   logic [NB_REG-1:0][REG_WIDTH-1:0]    offs_o;
   logic                                accum_o;
   modport master (
      output clear_i, enable_i, accum_loop_i, loops_i, code_i, range_i, ro_reg_i,
      input  valid_o, done_o, idx_o, offs_o, accum_o
   );
   modport slave (
      input  clear_i, enable_i, accum_loop_i, loops_i, code_i, range_i, ro_reg_i,
      output valid_o, done_o, idx_o, offs_o, accum_o
   );
endinterface

// File: rtl/hwpe_ctrl_ucode_seq.sv
// hwpe_ctrl_ucode_seq: nested-loop microcode sequencer driving streamer indices and offsets.
// Define HWPE_CTRL_UCODE_SEQ_STALL_EN to let enable_i gate op execution in EXEC.
module hwpe_ctrl_ucode_seq #(
   parameter int NB_LOOPS  = 6,
   parameter int LENGTH    = 17,
   parameter int NB_REG    = 4,
   parameter int NB_RO_REG = 28,
   parameter int REG_WIDTH = 32,
   parameter int CNT_WIDTH = 12
) (
   input logic clk_i,
   input logic rst_i,
   hwpe_ctrl_ucode_seq_if.slave ctrl
);
   localparam int LW = $clog2(NB_LOOPS);
   localparam int RW = $clog2(NB_REG);
   typedef enum logic [2:0] {FIRST, IDLE, EXEC, VALID, DONE} state_t;
   state_t state, state_n;
   logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx;
   logic [NB_REG-1:0][REG_WIDTH-1:0] regs;
   logic [NB_REG+NB_RO_REG-1:0][REG_WIDTH-1:0] space;
   logic [LW-1:0] level, lvl;
   logic [5:0] ptr;
   logic [2:0] rem;
   logic [10:0] op;
   logic found, accept, step, hit;
   // RW registers occupy the low operand indices, read-only ones follow
   assign space = {ctrl.ro_reg_i, regs};
   assign hit = ptr < 6'(LENGTH);
   assign op = ctrl.code_i[ptr[4:0]];
   assign accept = state == IDLE && ctrl.enable_i && found;
`ifdef HWPE_CTRL_UCODE_SEQ_STALL_EN
   assign step = state == EXEC && ctrl.enable_i;
`else
   assign step = state == EXEC;
`endif
   // lowest level whose counter has not yet reached its last iteration
   always_comb begin
      found = 1'b0;
      lvl = '0;
      for (int l = NB_LOOPS - 1; l >= 0; l--)
         if (idx[l] != (ctrl.range_i[l] == '0 ? '0 : ctrl.range_i[l] - 1'b1)) begin
            found = 1'b1;
            lvl = LW'(l);
         end
   end
   always_comb begin
      state_n = state;
      case (state)
         FIRST:   state_n = ctrl.enable_i ? VALID : FIRST;
         IDLE:    state_n = !ctrl.enable_i ? IDLE : !found ? DONE :
                            ctrl.loops_i[lvl][2:0] == '0 ? VALID : EXEC;
         EXEC:    state_n = step && rem == 3'd1 ? VALID : EXEC;
         VALID:   state_n = IDLE;
         default: state_n = DONE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= FIRST;
      else state <= ctrl.clear_i ? FIRST : state_n;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx <= '0;
         regs <= '0;
         level <= '0;
         ptr <= '0;
         rem <= '0;
      end else if (ctrl.clear_i) begin
         idx <= '0;
         regs <= '0;
         level <= '0;
         ptr <= '0;
         rem <= '0;
      end else if (accept) begin
         for (int l = 0; l < NB_LOOPS; l++)
            idx[l] <= LW'(l) < lvl ? '0 : LW'(l) == lvl ? idx[l] + 1'b1 : idx[l];
         level <= lvl;
         ptr <= {1'b0, ctrl.loops_i[lvl][7:3]};
         rem <= ctrl.loops_i[lvl][2:0];
      end else if (step) begin
         if (hit && op[9:5] < 5'(NB_REG))
            regs[op[5+:RW]] <= op[10] ? regs[op[5+:RW]] + space[op[4:0]] : space[op[4:0]];
         ptr <= ptr + 6'd1;
         rem <= rem - 3'd1;
      end
   end
   assign ctrl.valid_o = state == VALID;
   assign ctrl.done_o = state == DONE;
   assign ctrl.accum_o = state == VALID && level < ctrl.accum_loop_i;
   assign ctrl.idx_o = idx;
   assign ctrl.offs_o = regs;
endmodule
